// File: rtl/muldiv_unit_e_if.sv
// Execute-stage mul/div bundle: ID/EX operands and controls in, HI/LO and status out.
interface muldiv_unit_e_if #(
    parameter int unsigned WIDTH = 32
);
    logic             StartE;
    logic [1:0]       MulDivOpE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic             WriteHIE;
    logic             WriteLOE;
    logic             CancelE;
    logic             BusyE;
    logic             DoneE;
    logic             DivZeroE;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output StartE, MulDivOpE, SrcAE, SrcBE, WriteHIE, WriteLOE, CancelE,
        input  BusyE, DoneE, DivZeroE, HI, LO
    );

    modport slave (
        input  StartE, MulDivOpE, SrcAE, SrcBE, WriteHIE, WriteLOE, CancelE,
        output BusyE, DoneE, DivZeroE, HI, LO
    );
endinterface

// File: rtl/muldiv_unit_e.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: WIDTH iterations on magnitudes,
// then one sign-fix cycle that writes HI/LO.
module muldiv_unit_e #(
    parameter int unsigned WIDTH = 32
) (
    input logic            clk,
    input logic            rst_n,
    muldiv_unit_e_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               divzero_q, divzero_d;

    logic               signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc, div_acc, prod;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff, quo, rem;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

    always_comb begin
        signed_op = ~bus.MulDivOpE[0];
        a_neg     = signed_op & bus.SrcAE[WIDTH-1];
        b_neg     = signed_op & bus.SrcBE[WIDTH-1];
        a_mag     = a_neg ? -bus.SrcAE : bus.SrcAE;
        b_mag     = b_neg ? -bus.SrcBE : bus.SrcBE;

        // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_acc = {mul_sum, acc_q[WIDTH-1:1]};

        // Divide: acc = {partial remainder, dividend bits shifting into quotient bits}
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        if (div_shift >= {1'b0, opnd_q}) begin
            div_acc = {div_diff, acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_acc = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end

        prod = neg_res_q ? -acc_q : acc_q;
        quo  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        divzero_d = divzero_q;

        case (state_q)
            IDLE: begin
                if (bus.StartE) begin
                    state_d   = CALC;
                    cnt_d     = '0;
                    is_div_d  = bus.MulDivOpE[1];
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    divzero_d = bus.MulDivOpE[1] && (bus.SrcBE == '0);
                    if (bus.MulDivOpE[1]) begin
                        acc_d  = {{WIDTH{1'b0}}, a_mag};
                        opnd_d = b_mag;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, b_mag};
                        opnd_d = a_mag;
                    end
                end else begin
                    if (bus.WriteHIE) hi_d = bus.SrcAE;
                    if (bus.WriteLOE) lo_d = bus.SrcAE;
                end
            end
            CALC: begin
                acc_d = is_div_q ? div_acc : mul_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase

        // Cancel overrides every architectural effect of this cycle, including an IDLE start/MTHI/MTLO
        if (bus.CancelE) begin
            state_d   = IDLE;
            hi_d      = hi_q;
            lo_d      = lo_q;
            done_d    = 1'b0;
            divzero_d = 1'b0;
        end
    end

    assign bus.BusyE    = (state_q != IDLE);
    assign bus.DoneE    = done_q;
    assign bus.DivZeroE = divzero_q;
    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;
endmodule

// File: tb/tb_muldiv_unit_e.sv
// Scoreboard bench for muldiv_unit_e: directed ops queue expected HI/LO/DivZeroE,
// a negedge monitor compares on DoneE and drains queued status checks.
module tb_muldiv_unit_e;
    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        string        name;
    } exp_t;

    typedef struct {
        string       name;
        logic [63:0] act;
        logic [63:0] exp;
    } chk_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    chk_t chkq[$];

    always #5 clk = ~clk;

    muldiv_unit_e_if #(.WIDTH(W)) bus();
    muldiv_unit_e #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Monitor: sole place where comparisons are made and counted
    always @(negedge clk) begin
        chk_t c;
        exp_t e;
        while (chkq.size() > 0) begin
            c = chkq.pop_front();
            n_checks++;
            if (c.act !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", c.name, c.act, c.exp);
            end
        end
        if (rst_n === 1'b1 && bus.DoneE === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got DoneE=1 expected no result pending");
            end else begin
                e = sb.pop_front();
                if ({bus.DivZeroE, bus.HI, bus.LO} !== {e.dz, e.hi, e.lo}) begin
                    n_fail++;
                    $display("FAIL %s: got dz=%b HI=%h LO=%h expected dz=%b HI=%h LO=%h",
                             e.name, bus.DivZeroE, bus.HI, bus.LO, e.dz, e.hi, e.lo);
                end
            end
        end
    end

    task automatic push_chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chkq.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.StartE    = 1'b1;
        bus.MulDivOpE = op;
        bus.SrcAE     = a;
        bus.SrcBE     = b;
        tick();
        bus.StartE    = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] hi, input logic [W-1:0] lo,
                          input logic dz);
        exp_t e;
        int   n;
        e.hi = hi; e.lo = lo; e.dz = dz; e.name = name;
        sb.push_back(e);
        start_op(op, a, b);
        n = 0;
        while (bus.BusyE === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        push_chk({name, "_busy_len"}, 64'(n), 64'd33);
        tick();
        push_chk({name, "_done_pulse"}, 64'(bus.DoneE), 64'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.StartE    = 1'b0;
        bus.MulDivOpE = 2'b00;
        bus.SrcAE     = '0;
        bus.SrcBE     = '0;
        bus.WriteHIE  = 1'b0;
        bus.WriteLOE  = 1'b0;
        bus.CancelE   = 1'b0;
        repeat (3) tick();
        push_chk("rst_busy", 64'(bus.BusyE), 64'd0);
        push_chk("rst_hi", 64'(bus.HI), 64'd0);
        push_chk("rst_lo", 64'(bus.LO), 64'd0);
        push_chk("rst_done", 64'(bus.DoneE), 64'd0);
        push_chk("rst_dz", 64'(bus.DivZeroE), 64'd0);
        rst_n = 1'b1;
        tick();

        // MTHI then a cancelled MULT
        bus.WriteHIE = 1'b1;
        bus.SrcAE    = 32'h1234;
        tick();
        bus.WriteHIE = 1'b0;
        push_chk("mthi", 64'(bus.HI), 64'h1234);
        start_op(2'b00, 32'd2, 32'd3);
        repeat (9) tick();
        push_chk("cancel_busy_before", 64'(bus.BusyE), 64'd1);
        bus.CancelE = 1'b1;
        tick();
        bus.CancelE = 1'b0;
        push_chk("cancel_busy", 64'(bus.BusyE), 64'd0);
        push_chk("cancel_hi", 64'(bus.HI), 64'h1234);
        push_chk("cancel_lo", 64'(bus.LO), 64'd0);
        repeat (40) tick();

        // Cancel in IDLE blocks MTLO and StartE
        bus.CancelE  = 1'b1;
        bus.WriteLOE = 1'b1;
        bus.StartE   = 1'b1;
        bus.SrcAE    = 32'hDEAD;
        tick();
        bus.CancelE  = 1'b0;
        bus.WriteLOE = 1'b0;
        bus.StartE   = 1'b0;
        push_chk("cancel_idle_lo", 64'(bus.LO), 64'd0);
        push_chk("cancel_idle_busy", 64'(bus.BusyE), 64'd0);

        run_op("mult_neg3x7", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("mult_neg5xneg4", 2'b00, 32'hFFFFFFFB, 32'hFFFFFFFC, 32'h0, 32'd20, 1'b0);
        run_op("div_neg7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("div_7_neg2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op("divu_100_0", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1);
        repeat (3) tick();
        push_chk("dz_held", 64'(bus.DivZeroE), 64'd1);
        run_op("div_intmin_neg1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);

        // StartE wins over MTLO in the same IDLE cycle
        bus.WriteLOE = 1'b1;
        bus.SrcAE    = 32'h55;
        tick();
        bus.WriteLOE = 1'b0;
        push_chk("mtlo", 64'(bus.LO), 64'h55);
        bus.WriteLOE = 1'b1;
        start_op(2'b01, 32'd7, 32'd3);
        bus.WriteLOE = 1'b0;
        push_chk("start_beats_mtlo", 64'(bus.LO), 64'h55);
        begin
            exp_t e;
            int   n;
            e.hi = 32'h0; e.lo = 32'd21; e.dz = 1'b0; e.name = "multu_7x3";
            sb.push_back(e);
            n = 0;
            while (bus.BusyE === 1'b1 && n < 100) begin
                n++;
                tick();
            end
            push_chk("multu_7x3_busy_len", 64'(n), 64'd33);
            tick();
        end

        // Reset in the middle of CALC
        start_op(2'b01, 32'd5, 32'd5);
        repeat (19) tick();
        rst_n = 1'b0;
        tick();
        push_chk("midrst_busy", 64'(bus.BusyE), 64'd0);
        push_chk("midrst_hi", 64'(bus.HI), 64'd0);
        push_chk("midrst_lo", 64'(bus.LO), 64'd0);
        push_chk("midrst_done", 64'(bus.DoneE), 64'd0);
        rst_n = 1'b1;
        repeat (40) tick();
        push_chk("midrst_idle", 64'(bus.BusyE), 64'd0);

        push_chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
